// File: rtl/mdu_pkg.sv
// mdu_pkg: shared width default, func3 codes, FSM encoding and op predicates for the M-extension unit
package mdu_pkg;
  localparam int XLEN_DEF = 32;
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;
  typedef enum logic [1:0] {IDLE = 2'b00, CALC = 2'b01, FIN = 2'b10} state_t;
  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction
  function automatic logic is_signed_a(input logic [2:0] op);
    return op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM;
  endfunction
  function automatic logic is_signed_b(input logic [2:0] op);
    return op == OP_MULH || op == OP_DIV || op == OP_REM;
  endfunction
endpackage

// File: rtl/mdu_divstep.sv
// mdu_divstep: one combinational restoring-division step producing the next partial remainder and quotient bit
module mdu_divstep #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic            dbit,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic            q
);
  logic [XLEN:0] trial;
  assign trial    = {rem, dbit};
  assign q        = trial >= {1'b0, divisor};
  assign rem_next = q ? XLEN'(trial - {1'b0, divisor}) : trial[XLEN-1:0];
endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV32M multiply/divide unit; define MDU_FAST_MUL_EN for a single-cycle combinational multiplier
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic [XLEN-1:0] result,
  output logic            valid,
  output logic            busy
);
  localparam int CW = $clog2(XLEN);
  state_t            state;
  logic [2:0]        opr;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   mc;
  logic              neg_q, neg_r;
  logic              sa, sb, div_zero, ovf;
  logic [XLEN-1:0]   ma, mb;
  logic [XLEN-1:0]   nrem, q_mag, r_mag, fin_res;
  logic              qb;
  logic [XLEN:0]     msum;
  logic [2*XLEN-1:0] mul_next, div_next, full;
  assign sa       = is_signed_a(op) & rs1[XLEN-1];
  assign sb       = is_signed_b(op) & rs2[XLEN-1];
  assign ma       = sa ? -rs1 : rs1;
  assign mb       = sb ? -rs2 : rs2;
  assign div_zero = is_div(op) && rs2 == '0;
  assign ovf      = (op == OP_DIV || op == OP_REM) && rs1 == {1'b1, {(XLEN-1){1'b0}}} && rs2 == '1;
  mdu_divstep #(.XLEN(XLEN)) u_divstep (
    .rem      (acc[2*XLEN-1:XLEN]),
    .dbit     (acc[XLEN-1]),
    .divisor  (mc),
    .rem_next (nrem),
    .q        (qb)
  );
  // Shift-add keeps the multiplier in the low half and shifts the carry-extended partial sum in from the top
  assign msum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mc} : '0);
  assign mul_next = {msum, acc[XLEN-1:1]};
  assign div_next = {nrem, acc[XLEN-2:0], qb};
  // Sign fixup works on magnitudes; special cases enter with both signs cleared so raw values pass through
  assign full     = neg_q ? -acc : acc;
  assign q_mag    = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign r_mag    = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
  assign fin_res  = is_div(opr) ? (opr[1] ? r_mag : q_mag) :
                    (opr == OP_MUL ? full[XLEN-1:0] : full[2*XLEN-1:XLEN]);
`ifdef MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] prod;
  assign prod = {{XLEN{1'b0}}, ma} * {{XLEN{1'b0}}, mb};
`endif
  // Control FSM: accept in IDLE, iterate in CALC, register the fixed-up result and pulse valid from FIN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      opr    <= '0;
      cnt    <= '0;
      acc    <= '0;
      mc     <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
      valid  <= 1'b0;
      busy   <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: if (start) begin
          opr  <= op;
          cnt  <= '0;
          busy <= 1'b1;
          if (div_zero || ovf) begin
            acc   <= div_zero ? {rs1, {XLEN{1'b1}}} : {{XLEN{1'b0}}, rs1};
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            state <= FIN;
          end else begin
            acc   <= {{XLEN{1'b0}}, is_div(op) ? ma : mb};
            mc    <= is_div(op) ? mb : ma;
            neg_q <= sa ^ sb;
            neg_r <= sa;
            state <= CALC;
`ifdef MDU_FAST_MUL_EN
            if (!is_div(op)) begin
              acc   <= prod;
              state <= FIN;
            end
`endif
          end
        end
        CALC: begin
          acc   <= is_div(opr) ? div_next : mul_next;
          cnt   <= cnt + 1'b1;
          state <= cnt == CW'(XLEN-1) ? FIN : CALC;
        end
        FIN: begin
          result <= fin_res;
          valid  <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: scoreboard bench for mdu_iter with directed RV32M vectors, latency and reset checks
module tb_mdu_iter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] rs1 = '0, rs2 = '0;
  logic [31:0] result;
  logic        valid, busy;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  typedef struct {
    logic [31:0] res;
    int          acc_cyc;
    int          lat;
    string       name;
  } exp_t;
  exp_t sbq[$];
  mdu_iter #(.XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .rs1    (rs1),
    .rs2    (rs2),
    .result (result),
    .valid  (valid),
    .busy   (busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Monitor: every completion must match the oldest outstanding expectation in value and latency
  always @(negedge clk) begin
    if (!rst && valid) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid result=%h expected no completion", result);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        tests++;
        if (result !== e.res) begin
          fails++;
          $display("FAIL %s result got=%h exp=%h", e.name, result, e.res);
        end
        tests++;
        if (cyc - e.acc_cyc + 1 != e.lat) begin
          fails++;
          $display("FAIL %s latency got=%0d exp=%0d", e.name, cyc - e.acc_cyc + 1, e.lat);
        end
      end
    end
  end
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input int lat, input string name, input bit push);
    @(negedge clk);
    start = 1'b1; op = o; rs1 = a; rs2 = b;
    @(posedge clk); #1;
    if (push) sbq.push_back('{res, cyc, lat, name});
    start = 1'b0;
  endtask
  task automatic wait_done(input string name);
    int n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    if (sbq.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL %s timeout pending=%0d expected 0", name, sbq.size());
      sbq.delete();
    end
  endtask
  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("reset_result", result, 32'h0);
    check("reset_valid", {31'b0, valid}, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'h0);
    rst = 1'b0;
    issue(3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 34, "mul", 1);
    @(negedge clk);
    check("busy_early", {31'b0, busy}, 32'h1);
    repeat (20) @(negedge clk);
    check("busy_mid", {31'b0, busy}, 32'h1);
    wait_done("mul");
    issue(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34, "mulh", 1);  wait_done("mulh");
    issue(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, "mulhu", 1); wait_done("mulhu");
    issue(3'b010, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 34, "mulhsu", 1);       wait_done("mulhsu");
    issue(3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34, "div_neg", 1);      wait_done("div_neg");
    issue(3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34, "rem_neg", 1);      wait_done("rem_neg");
    issue(3'b111, 32'd100, 32'd7, 32'd2, 34, "remu", 1);                     wait_done("remu");
    issue(3'b100, 32'd5, 32'd0, 32'hFFFFFFFF, 2, "div_by_zero", 1);          wait_done("div_by_zero");
    issue(3'b110, 32'd5, 32'd0, 32'd5, 2, "rem_by_zero", 1);                 wait_done("rem_by_zero");
    issue(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2, "div_ovf", 1); wait_done("div_ovf");
    issue(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0, 2, "rem_ovf", 1);       wait_done("rem_ovf");
    check("result_held", result, 32'h0);
    issue(3'b101, 32'd100, 32'd7, 32'd14, 34, "divu_start_held", 1);
    start = 1'b1; op = 3'b000; rs1 = 32'd3; rs2 = 32'd3;
    repeat (10) @(negedge clk);
    start = 1'b0;
    wait_done("divu_start_held");
    repeat (40) @(negedge clk);
    issue(3'b111, 32'd100, 32'd7, 32'd2, 34, "b2b_first", 1);
    n = 0;
    while (!valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (!valid) begin
      fails++;
      $display("FAIL b2b_first_valid got=0 exp=1");
    end
    start = 1'b1; op = 3'b011; rs1 = 32'hFFFFFFFF; rs2 = 32'hFFFFFFFF;
    @(posedge clk); #1;
    sbq.push_back('{32'hFFFFFFFE, cyc, 34, "b2b_second"});
    start = 1'b0;
    wait_done("b2b");
    issue(3'b100, 32'd100, 32'd7, 32'd14, 34, "aborted_div", 0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_result", result, 32'h0);
    check("abort_busy", {31'b0, busy}, 32'h0);
    check("abort_valid", {31'b0, valid}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    issue(3'b101, 32'd9, 32'd3, 32'd3, 34, "divu_after_reset", 1);
    wait_done("divu_after_reset");
    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
